// File: rtl/left_shift_seq.sv
// left_shift_seq: multi-cycle logical left shifter (B = A << C, STEP bits per clock) with start/done handshake and Z/N flags.
// Define LEFT_SHIFT_CARRY_EN to add the CY output (last bit shifted out).
module left_shift_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [31:0]      C,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] B,
  output logic             Z,
  output logic             N
`ifdef LEFT_SHIFT_CARRY_EN
  ,
  output logic             CY
`endif
);

  localparam logic [31:0] WIDTH32 = 32'(WIDTH);
  localparam logic [31:0] STEP32  = 32'(STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shifted;
  logic [31:0]      cnt;
  logic [31:0]      amt;

  // The final step may be shorter than STEP when fewer bits remain.
  always_comb begin
    amt     = (cnt < STEP32) ? cnt : STEP32;
    shifted = acc << amt;
  end

`ifdef LEFT_SHIFT_CARRY_EN
  // Bit 0 of spill is acc[WIDTH-amt], the last bit discarded by this step.
  logic [WIDTH-1:0] spill;
  always_comb begin
    spill = acc >> (WIDTH32 - amt);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      B     <= '0;
      Z     <= 1'b1;
      N     <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
`ifdef LEFT_SHIFT_CARRY_EN
      CY    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ready <= 1'b0;
            acc   <= A;
            cnt   <= C;
            if (C == 32'd0) begin
              state <= DONE;
              done  <= 1'b1;
              B     <= A;
              Z     <= (A == '0);
              N     <= A[WIDTH-1];
`ifdef LEFT_SHIFT_CARRY_EN
              CY    <= 1'b0;
`endif
            end else if (C >= WIDTH32) begin
              // Everything is shifted out, so skip iteration entirely.
              acc   <= '0;
              state <= DONE;
              done  <= 1'b1;
              B     <= '0;
              Z     <= 1'b1;
              N     <= 1'b0;
`ifdef LEFT_SHIFT_CARRY_EN
              CY    <= (C == WIDTH32) ? A[0] : 1'b0;
`endif
            end else begin
              state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          acc <= shifted;
          cnt <= cnt - amt;
          if (cnt == amt) begin
            state <= DONE;
            done  <= 1'b1;
            B     <= shifted;
            Z     <= (shifted == '0);
            N     <= shifted[WIDTH-1];
`ifdef LEFT_SHIFT_CARRY_EN
            CY    <= spill[0];
`endif
          end
        end

        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_left_shift_seq.sv
// tb_left_shift_seq: randomized scoreboard bench for left_shift_seq.
// Expected results come from plain shift arithmetic; a monitor pops them whenever done pulses.
module tb_left_shift_seq;

  localparam int WIDTH = 32;
  localparam int STEP  = 1;

  typedef struct {
    logic [WIDTH-1:0] b;
    logic             z;
    logic             n;
    logic             cy;
    int               lat;
    int               acceptCyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [31:0]      C = '0;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] B;
  logic             Z;
  logic             N;
`ifdef LEFT_SHIFT_CARRY_EN
  logic             CY;
`endif

  exp_t             expQ[$];
  int               cyc = 0;
  int               checkCount = 0;
  int               passCount = 0;
  bit               holdEn = 1'b0;
  logic [WIDTH-1:0] lastB = '0;
  logic             lastZ = 1'b1;
  logic             lastN = 1'b0;

  left_shift_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .C     (C),
    .ready (ready),
    .done  (done),
    .B     (B),
    .Z     (Z),
    .N     (N)
`ifdef LEFT_SHIFT_CARRY_EN
    ,
    .CY    (CY)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Accept one operation and push the reference result onto the scoreboard.
  task automatic issueOp(input logic [WIDTH-1:0] a, input logic [31:0] c, input bit hold);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checkOutput("ready_timeout", {63'd0, ready}, 64'd1);
      return;
    end
    A = a;
    C = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.b   = (c >= 32'(WIDTH)) ? '0 : (a << c);
    e.z   = (e.b == '0);
    e.n   = e.b[WIDTH-1];
    e.cy  = (c >= 32'd1 && c <= 32'(WIDTH)) ? a[WIDTH - int'(c)] : 1'b0;
    e.lat = (c == 32'd0 || c >= 32'(WIDTH)) ? 1 : (int'(c) + STEP - 1) / STEP + 1;
    e.acceptCyc = cyc;
    expQ.push_back(e);
    if (hold) begin
      n = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < 200) begin
        A = $urandom;
        C = $urandom_range(0, WIDTH + 8);
        n++;
        @(negedge clk);
      end
      start = 1'b0;
    end else begin
      start = 1'b0;
      A = $urandom;
      C = $urandom;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
      expQ.delete();
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [31:0] c, input bit hold);
    issueOp(a, c, hold);
    waitDrain();
  endtask

  task automatic checkResetState();
    checkOutput("rst_B", 64'(B), 64'd0);
    checkOutput("rst_Z", {63'd0, Z}, 64'd1);
    checkOutput("rst_N", {63'd0, N}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_ready", {63'd0, ready}, 64'd1);
`ifdef LEFT_SHIFT_CARRY_EN
    checkOutput("rst_CY", {63'd0, CY}, 64'd0);
`endif
    lastB = '0;
    lastZ = 1'b1;
    lastN = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("B", 64'(B), 64'(e.b));
        checkOutput("Z", {63'd0, Z}, {63'd0, e.z});
        checkOutput("N", {63'd0, N}, {63'd0, e.n});
`ifdef LEFT_SHIFT_CARRY_EN
        checkOutput("CY", {63'd0, CY}, {63'd0, e.cy});
`endif
        checkOutput("latency", 64'(cyc - e.acceptCyc + 1), 64'(e.lat));
        checkOutput("ready_in_done", {63'd0, ready}, 64'd0);
        lastB = e.b;
        lastZ = e.z;
        lastN = e.n;
      end
    end else if (holdEn) begin
      checkOutput("hold_BZN", 64'({B, Z, N}), 64'({lastB, lastZ, lastN}));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState();
    rst_n = 1'b1;
    holdEn = 1'b1;

    $display("[TB] directed cases");
    applyStimulus(32'h0000_0001, 32'd31, 1'b0);
    applyStimulus(32'h8000_0001, 32'd1, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'd40, 1'b0);
    applyStimulus(32'hF000_0000, 32'd0, 1'b0);
    applyStimulus(32'h0000_000F, 32'd8, 1'b1);
    applyStimulus(32'h1234_5678, 32'd32, 1'b0);

    $display("[TB] mid-operation reset");
    issueOp(32'h0000_0001, 32'd20, 1'b0);
    repeat (4) @(negedge clk);
    holdEn = 1'b0;
    expQ.delete();
    rst_n = 1'b0;
    @(negedge clk);
    checkResetState();
    rst_n = 1'b1;
    holdEn = 1'b1;
    repeat (25) @(negedge clk);
    applyStimulus(32'h0000_0003, 32'd4, 1'b0);

    $display("[TB] randomized cases");
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra;
      logic [31:0]      rc;
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rc = 32'd0;
        1: rc = $urandom;
        2: rc = 32'(WIDTH);
        default: rc = $urandom_range(1, WIDTH - 1);
      endcase
      applyStimulus(ra, rc, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
